line_cmd_sequencer: RTL and testbench

//  Parametrised command sequencer for the line-following follower. It sits between UART_wrapper and the PID/IR_intf path.

---
 rtl/line_cmd_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_sequencer.sv
// Command sequencer for the line follower: buffers UART command words and runs their 2-bit steps.
// Optional stall watchdog enabled by defining STALL_WDOG_EN.
module line_cmd_sequencer #(
  parameter int          CMD_W      = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TMR_W      = 26,
  parameter int          TURN1_CYC  = 10 << 16,
  parameter int          TURN2_CYC  = 16 << 16,
  parameter int          DBNC_CYC   = 1 << 17,
  parameter logic [15:0] VEER_MAG   = 16'h340,
  parameter logic [15:0] TURN1_MAG  = 16'h1E0,
  parameter logic [15:0] TURN2_MAG  = 16'h380
`ifdef STALL_WDOG_EN
  , parameter int        WDOG_CYC   = 1 << 22
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CMD_W-1:0]    cmd,
  input  logic                cmd_rdy,
  output logic                clr_cmd_rdy,
  input  logic                line_present,
  input  logic                BMP_n,
  output logic                go,
  output logic signed [15:0]  err_opn_lp,
  output logic                buzz,
  output logic                fifo_full,
  output logic                busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TURN1_LAST = TMR_W'(TURN1_CYC - 1);
  localparam logic [TMR_W-1:0] TURN2_LAST = TMR_W'(TURN2_CYC - 1);
  localparam logic [TMR_W-1:0] DBNC_LAST  = TMR_W'(DBNC_CYC - 1);
`ifdef STALL_WDOG_EN
  localparam logic [TMR_W-1:0] WDOG_LAST  = TMR_W'(WDOG_CYC - 1);
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_MOVE, S_VEER, S_TURN1, S_TURN2, S_AWAIT, S_DBNC, S_HOLD
`ifdef STALL_WDOG_EN
    , S_STALL
`endif
  } state_t;

  state_t             r_state;
  logic [CMD_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic [CMD_W-1:0]   r_cmd_reg;
  logic               r_last_veer_rght;
  logic [TMR_W-1:0]   r_tmr;

  state_t             w_nxt_state;
  logic [1:0]         w_step;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_nxt_cmd;
  logic               w_clr_tmr;
  logic               w_go;
  logic               w_buzz;
  logic signed [15:0] w_err;
`ifdef STALL_WDOG_EN
  logic               w_flush;
`endif

  assign w_step  = r_cmd_reg[1:0];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_push  = cmd_rdy & ~w_full;

  // Next-state and output decode; go/buzz may follow line_present/BMP_n within the cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_go        = 1'b0;
    w_buzz      = 1'b0;
    w_err       = '0;
    w_pop       = 1'b0;
    w_nxt_cmd   = 1'b0;
    w_clr_tmr   = 1'b0;
`ifdef STALL_WDOG_EN
    w_flush     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty && line_present) begin
          w_pop       = 1'b1;
          w_go        = 1'b1;
          w_nxt_state = S_MOVE;
        end
      end
      S_MOVE: begin
        w_go = 1'b1;
        if (line_present) begin
          if (!BMP_n) begin
            w_go        = 1'b0;
            w_clr_tmr   = 1'b1;
            w_nxt_state = S_DBNC;
          end
        end else begin
          case (w_step)
            2'b11: begin
              w_go        = 1'b0;
              w_clr_tmr   = 1'b1;
              w_nxt_state = S_TURN1;
            end
            2'b01, 2'b10: begin
`ifdef STALL_WDOG_EN
              w_clr_tmr   = 1'b1;
`endif
              w_nxt_state = S_VEER;
            end
            default: begin
              if (!w_empty) begin
                w_pop = 1'b1;
              end else begin
                w_go        = 1'b0;
                w_nxt_state = S_IDLE;
              end
            end
          endcase
        end
      end
      S_VEER: begin
        w_go  = 1'b1;
        w_err = r_last_veer_rght ? $signed(VEER_MAG) : -$signed(VEER_MAG);
        if (line_present) begin
          w_nxt_cmd   = 1'b1;
          w_nxt_state = S_MOVE;
`ifdef STALL_WDOG_EN
        end else if (r_tmr == WDOG_LAST) begin
          w_flush     = 1'b1;
          w_nxt_state = S_STALL;
`endif
        end
      end
      S_TURN1: begin
        w_go  = 1'b1;
        w_err = r_last_veer_rght ? -$signed(TURN1_MAG) : $signed(TURN1_MAG);
        if (r_tmr == TURN1_LAST) begin
          w_go        = 1'b0;
          w_clr_tmr   = 1'b1;
          w_nxt_state = S_TURN2;
        end
      end
      S_TURN2: begin
        w_go  = 1'b1;
        w_err = r_last_veer_rght ? $signed(TURN2_MAG) : -$signed(TURN2_MAG);
        if (r_tmr == TURN2_LAST) begin
`ifdef STALL_WDOG_EN
          w_clr_tmr   = 1'b1;
`endif
          w_nxt_state = S_AWAIT;
        end
      end
      S_AWAIT: begin
        w_go = 1'b1;
        if (line_present) begin
          w_nxt_cmd   = 1'b1;
          w_nxt_state = S_MOVE;
`ifdef STALL_WDOG_EN
        end else if (r_tmr == WDOG_LAST) begin
          w_flush     = 1'b1;
          w_nxt_state = S_STALL;
`endif
        end
      end
      S_DBNC: begin
        w_buzz = 1'b1;
        if (r_tmr == DBNC_LAST) w_nxt_state = S_HOLD;
      end
      S_HOLD: begin
        w_buzz = ~BMP_n;
        if (BMP_n) w_nxt_state = S_MOVE;
      end
`ifdef STALL_WDOG_EN
      S_STALL: begin
        w_buzz = 1'b1;
        if (cmd_rdy) w_nxt_state = S_IDLE;
      end
`endif
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Word storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_cmd_reg        <= '0;
      r_last_veer_rght <= 1'b0;
      r_tmr            <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_tmr   <= w_clr_tmr ? '0 : r_tmr + 1'b1;
      if (w_nxt_cmd && (w_step == 2'b01 || w_step == 2'b10))
        r_last_veer_rght <= r_cmd_reg[0];
`ifdef STALL_WDOG_EN
      if (w_flush) begin
        r_rd_ptr  <= r_wr_ptr;
        r_wr_ptr  <= r_wr_ptr + PTR_W'(w_push);
        r_count   <= (PTR_W+1)'(w_push);
        r_cmd_reg <= '0;
      end else
`endif
      begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        r_count  <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        if (w_pop)
          r_cmd_reg <= r_fifo[r_rd_ptr];
        else if (w_nxt_cmd)
          r_cmd_reg <= {2'b00, r_cmd_reg[CMD_W-1:2]};
      end
    end
  end

  assign clr_cmd_rdy = w_push;
  assign go          = w_go;
  assign err_opn_lp  = w_err;
  assign buzz        = w_buzz;
  assign fifo_full   = w_full;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Randomized bench for line_cmd_sequencer: scripted drive of the robot with a queue-based
// model of buffered words and current step; expected outputs follow the step rules.
module tb_line_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int T1CYC  = 12;
  localparam int T2CYC  = 20;
  localparam int DBCYC  = 16;
  localparam logic [15:0] VEER  = 16'h0340;
  localparam logic [15:0] TURN1 = 16'h01E0;
  localparam logic [15:0] TURN2 = 16'h0380;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] cmd;
  logic        cmdRdy;
  logic        clrCmdRdy;
  logic        linePresent;
  logic        bmpN;
  logic        go;
  logic [15:0] errOpnLp;
  logic        buzz;
  logic        fifoFull;
  logic        busy;

  int          checkCount = 0;
  int          failCount  = 0;
  int          cycleCount = 0;
  logic [15:0] q[$];
  logic [15:0] cur;
  logic        lastVeer;
  logic        pendValid;
  logic [15:0] pendWord;
  int          pushBudget;
  int          pushRate;

  line_cmd_sequencer #(
    .CMD_W(16), .FIFO_DEPTH(DEPTH), .TMR_W(26),
    .TURN1_CYC(T1CYC), .TURN2_CYC(T2CYC), .DBNC_CYC(DBCYC),
    .VEER_MAG(VEER), .TURN1_MAG(TURN1), .TURN2_MAG(TURN2)
`ifdef STALL_WDOG_EN
    , .WDOG_CYC(4000)
`endif
  ) dut (
    .clk(clk), .rst_n(rstN), .cmd(cmd), .cmd_rdy(cmdRdy), .clr_cmd_rdy(clrCmdRdy),
    .line_present(linePresent), .BMP_n(bmpN), .go(go), .err_opn_lp(errOpnLp),
    .buzz(buzz), .fifo_full(fifoFull), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", tag, cycleCount, actual, expected);
    end
  endtask

  function automatic logic [15:0] neg16(input logic [15:0] v);
    return 16'h0000 - v;
  endfunction

  function automatic logic [15:0] genWord();
    int n;
    logic [15:0] mask;
    n = $urandom_range(1, 4);
    mask = 16'((32'd1 << (2 * n)) - 1);
    return 16'($urandom) & mask;
  endfunction

  // One clock: drive inputs at negedge, check outputs, then account for any accepted push.
  task automatic applyStimulus(input logic line, input logic bmp, input logic expGo,
                               input logic [15:0] expErr, input logic expBuzz, input logic expBusy);
    logic expClr;
    @(negedge clk);
    if (!pendValid && pushBudget > 0 && $urandom_range(0, 99) < pushRate) begin
      pendValid = 1'b1;
      pendWord  = genWord();
      pushBudget--;
    end
    linePresent = line;
    bmpN        = bmp;
    cmdRdy      = pendValid;
    cmd         = pendWord;
    #1;
    expClr = pendValid && (q.size() < DEPTH);
    checkOutput("go", go, expGo);
    checkOutput("err", errOpnLp, expErr);
    checkOutput("buzz", buzz, expBuzz);
    checkOutput("busy", busy, expBusy);
    checkOutput("clr_cmd_rdy", clrCmdRdy, expClr);
    checkOutput("fifo_full", fifoFull, q.size() == DEPTH);
    if (expClr) begin
      q.push_back(pendWord);
      pendValid = 1'b0;
    end
    cycleCount++;
    if (cycleCount > 60000) begin
      $display("[TB] FAIL cycle_budget cycle=%0d actual=over expected=under_60000", cycleCount);
      $fatal(1, "[TB] cycle budget exhausted");
    end
  endtask

  task automatic doBump();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < DBCYC; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b1, 1'b1);
    repeat ($urandom_range(0, 2))
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic doTurn(input int t2Cycles);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < T1CYC; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i != T1CYC - 1),
                    lastVeer ? neg16(TURN1) : TURN1, 1'b0, 1'b1);
    for (int i = 0; i < t2Cycles; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                    lastVeer ? TURN2 : neg16(TURN2), 1'b0, 1'b1);
  endtask

  // Executes buffered words from an IDLE start until the robot returns to IDLE.
  task automatic runWords();
    logic [1:0]  step;
    logic [15:0] veerErr;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    cur = q.pop_front();
    forever begin
      repeat ($urandom_range(0, 3)) applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
      if ($urandom_range(0, 5) == 0) doBump();
      step = cur[1:0];
      if (step == 2'b00) begin
        if (q.size() > 0) begin
          applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
          cur = q.pop_front();
        end else begin
          applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
          break;
        end
      end else if (step == 2'b11) begin
        doTurn(T2CYC);
        repeat ($urandom_range(0, 3))
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        cur = cur >> 2;
      end else begin
        veerErr = lastVeer ? VEER : neg16(VEER);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        repeat ($urandom_range(1, 4))
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, veerErr, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, veerErr, 1'b0, 1'b1);
        lastVeer = cur[0];
        cur = cur >> 2;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_go"}, go, 1'b0);
    checkOutput({tag, "_err"}, errOpnLp, 16'h0);
    checkOutput({tag, "_buzz"}, buzz, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_fifo_full"}, fifoFull, 1'b0);
    checkOutput({tag, "_clr"}, clrCmdRdy, 1'b0);
  endtask

  initial begin
    rstN = 1'b0; cmd = '0; cmdRdy = 1'b0; linePresent = 1'b0; bmpN = 1'b1;
    lastVeer = 1'b0; pendValid = 1'b0; pendWord = '0; cur = '0;
    pushBudget = 14; pushRate = 8;
    repeat (2) @(negedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    while (pushBudget > 0 || pendValid || q.size() > 0) begin
      pushRate = 50;
      while (q.size() == 0)
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 8))
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      pushRate = ($urandom_range(0, 2) == 0) ? 40 : 8;
      runWords();
    end

    // Fill the FIFO, hold a fifth word pending, start a turn and reset during its second phase.
    pendWord = 16'h0003; pendValid = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pendWord = genWord(); pendValid = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
    cur = q.pop_front();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
    doTurn(5);
    @(negedge clk);
    rstN = 1'b0; cmdRdy = 1'b0; linePresent = 1'b1;
    #1;
    checkAllZero("mid_reset");
    q.delete(); pendValid = 1'b0; lastVeer = 1'b0; cur = '0;
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
